// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin arbiter sharing one combinational ALU among NUM_REQ
// requesters. The ALU result and flags are captured into a one-entry response buffer
// and tagged with the winning requester's index.
// Latency: 1 cycle from accept (req_ready high) to resp_valid. Up to 1 op per cycle.
// Backpressure: a full buffer that is not being drained (resp_valid & !resp_ready)
// stalls every requester (req_ready = 0). Response fields hold until taken.
// Optional macro ALU_ARB_LOCK_EN: req_lock[i] on a grant pins further grants to i
// until a grant to i with req_lock[i] = 0.
// Ports: clk/rst_n (async active-low); req_valid/req_ready/req_a/req_b/req_sel/req_lock
// per requester, packed; alu_a/alu_b/alu_sel drive the shared ALU; alu_out/alu_zero/
// alu_overflow/alu_ge come back from it; resp_valid/resp_ready/resp_id/resp_out/
// resp_zero/resp_overflow/resp_ge form the registered response.
module alu_share_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [32*NUM_REQ-1:0]   req_a,
   input  logic [32*NUM_REQ-1:0]   req_b,
   input  logic [2*NUM_REQ-1:0]    req_sel,
   input  logic [NUM_REQ-1:0]      req_lock,
   output logic [31:0]             alu_a,
   output logic [31:0]             alu_b,
   output logic [1:0]              alu_sel,
   input  logic [31:0]             alu_out,
   input  logic                    alu_zero,
   input  logic                    alu_overflow,
   input  logic                    alu_ge,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [ID_W-1:0]         resp_id,
   output logic [31:0]             resp_out,
   output logic                    resp_zero,
   output logic                    resp_overflow,
   output logic                    resp_ge
);

   // ALU select encoding shared with the ALU (ADD is the idle drive value).
   localparam logic [1:0] ALU_SEL_ADD = 2'b00;

   typedef enum logic {ST_EMPTY, ST_FULL} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [ID_W-1:0]      r_last_grant;
   logic [ID_W-1:0]      w_gnt_idx;
   logic                 w_found;
   logic                 w_slot_free;
   logic                 w_any_gnt;
   logic [NUM_REQ-1:0]   w_grant;
   logic [NUM_REQ-1:0]   w_req_eff;

`ifdef ALU_ARB_LOCK_EN
   logic                 r_locked;
   logic [NUM_REQ-1:0]   w_last_oh;

   // While locked, last_grant still names the lock owner, since no one else can win.
   assign w_last_oh = NUM_REQ'(1) << r_last_grant;
   assign w_req_eff = r_locked ? (req_valid & w_last_oh) : req_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_locked <= 1'b0;
      end else if (w_any_gnt) begin
         r_locked <= |(req_lock & w_grant);
      end
   end
`else
   logic w_unused_lock;

   assign w_req_eff     = req_valid;
   assign w_unused_lock = ^req_lock;
`endif

   // A same-cycle drain frees the slot, so a full buffer can be refilled back-to-back.
   assign w_slot_free = (r_state == ST_EMPTY) | resp_ready;

   // Round-robin: first pass looks above last_grant, second pass wraps to the bottom.
   always_comb begin
      w_found   = 1'b0;
      w_gnt_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!w_found && w_req_eff[i] && (ID_W'(i) > r_last_grant)) begin
            w_found   = 1'b1;
            w_gnt_idx = ID_W'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!w_found && w_req_eff[i]) begin
            w_found   = 1'b1;
            w_gnt_idx = ID_W'(i);
         end
      end
   end

   assign w_any_gnt = w_found & w_slot_free;
   assign w_grant   = w_any_gnt ? (NUM_REQ'(1) << w_gnt_idx) : '0;
   assign req_ready = w_grant;

   always_comb begin
      alu_a   = '0;
      alu_b   = '0;
      alu_sel = ALU_SEL_ADD;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) begin
            alu_a   = req_a[32*i +: 32];
            alu_b   = req_b[32*i +: 32];
            alu_sel = req_sel[2*i +: 2];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_any_gnt) begin
         w_state_nxt = ST_FULL;
      end else if (resp_ready) begin
         w_state_nxt = ST_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Payload only moves on a grant, so it stays frozen while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_grant  <= ID_W'(NUM_REQ - 1);
         resp_id       <= '0;
         resp_out      <= '0;
         resp_zero     <= 1'b0;
         resp_overflow <= 1'b0;
         resp_ge       <= 1'b0;
      end else if (w_any_gnt) begin
         r_last_grant  <= w_gnt_idx;
         resp_id       <= w_gnt_idx;
         resp_out      <= alu_out;
         resp_zero     <= alu_zero;
         resp_overflow <= alu_overflow;
         resp_ge       <= alu_ge;
      end
   end

   assign resp_valid = (r_state == ST_FULL);

endmodule
